fetch_buffer: RTL
=================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning PC and memory address width.
REQ-002 SHALL have parameter INST_W, default 32, meaning instruction width (bits [6:0] opcode, RISC-V field layout).
REQ-003 SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on posedge clk.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port mem_req_valid  out  1  fetch request present.
REQ-008 SHALL have port mem_req_addr  out  ADDR_W  fetch address.
REQ-009 SHALL have port mem_req_ready  in  1  memory accepts request this cycle.
REQ-010 SHALL have port mem_rsp_valid  in  1  response data valid; responses return in request order, latency >=1 cycle.
REQ-011 SHALL have port mem_rsp_data  in  INST_W  fetched instruction word.
REQ-012 SHALL have port redirect_valid  in  1  downstream branch/jump redirect.
REQ-013 SHALL have port redirect_pc  in  ADDR_W  redirect target.
REQ-014 SHALL have port out_valid  out  1  queue head valid.
REQ-015 SHALL have port out_ready  in  1  decode accepts head.
REQ-016 SHALL have ports out_pc (ADDR_W), out_inst (INST_W), out_rs1/out_rs2/out_rd (5 each, from inst [19:15]/[24:20]/[11:7]), out_is_jal (1)  out  queue head fields.

Function
REQ-017 SHALL hold fetch_pc; a request is issued (mem_req_valid=1, mem_req_addr=fetch_pc) whenever count + inflight < DEPTH and redirect_valid=0.
REQ-018 SHALL advance fetch_pc by 4 (modulo 2^ADDR_W, wrap from max to 0) on each accepted request (mem_req_valid & mem_req_ready).
REQ-019 SHALL track inflight = accepted requests minus received responses; inflight never exceeds DEPTH.
REQ-020 SHALL enqueue each non-dropped response with its request PC (PC held in an inflight-address FIFO of DEPTH entries).
REQ-021 SHALL predecode out_is_jal = (opcode == 7'b1101111) at enqueue.
REQ-022 SHALL, on enqueue of a JAL, set fetch_pc to entry PC + sign-extended J-immediate {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}, truncated to ADDR_W, and mark all then-inflight requests as drop.
REQ-023 SHALL issue no request in the cycle a JAL is enqueued; the target request is issued at earliest the following cycle.
REQ-024 SHALL, on redirect_valid, empty the queue, set fetch_pc to redirect_pc, set drop_cnt to inflight minus any response arriving that cycle, and issue no request that cycle.
REQ-025 SHALL discard (not enqueue) responses while drop_cnt > 0, decrementing drop_cnt per discarded response.
REQ-026 SHALL give redirect priority over a same-cycle JAL enqueue; the JAL response is discarded and its target ignored.
REQ-027 SHALL treat out_valid & out_ready in a redirect cycle as a completed transfer, then flush.
REQ-028 SHALL allow simultaneous enqueue and dequeue when full (count unchanged); out_valid = (count != 0); head fields are don't-care when out_valid=0.
REQ-029 SHALL never overflow: enqueue is guaranteed by the credit rule in REQ-017, without reliance on out_ready.
REQ-030 SHALL present out_* registered from queue storage (no combinational path from mem_rsp_data to out_*).

Reset
REQ-031 SHALL, while reset=1, force fetch_pc=RESET_PC, count=0, inflight=0, drop_cnt=0, out_valid=0, mem_req_valid=0, regardless of clk.
REQ-032 SHALL issue the first request at RESET_PC in the first clock edge cycle after reset deasserts.
REQ-033 SHALL ignore responses for requests issued before reset (memory is reset together with this block).

Verification
REQ-034 Reset release, mem always ready, 1-cycle latency, NOPs, out_ready=1 -> mem_req_addr 0,4,8,..., out_pc follows same sequence, one instruction per cycle after 2-cycle fill.
REQ-035 out_ready=0 with DEPTH=4 -> exactly 4 entries queued, mem_req_valid=0 thereafter, no lost or duplicated PC on release.
REQ-036 JAL at PC 0x0010 with imm +0x20 -> request 0x0014 issued but response discarded; next out_pc after 0x0010 is 0x0030.
REQ-037 redirect_valid with redirect_pc=0x0100 while 2 requests inflight -> queue empty next cycle, both old responses dropped, next out_pc 0x0100.
REQ-038 fetch_pc=0xFFFC (ADDR_W=16) sequential -> next request address 0x0000.
REQ-039 reset asserted mid-stream with queue full and requests inflight -> out_valid=0 and mem_req_valid=0 immediately (asynchronously), restart at RESET_PC.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer
//    Instruction fetch front end. Issues sequential word fetches from
//    fetch_pc, remembers the PC of each outstanding request, queues returned
//    instructions together with their PC and predecoded fields, and follows
//    JAL targets and downstream redirects. It discards the responses of
//    requests that were on the abandoned path.
//
//    A request is issued only while queued + outstanding < DEPTH. Every
//    response therefore has a free queue slot, whatever the decode stage does.
//
// Ports
//    clk, reset              clock, asynchronous active-high reset
//    mem_req_valid/addr      fetch request to memory
//    mem_req_ready           memory accepts the request this cycle
//    mem_rsp_valid/data      in-order instruction response (latency >= 1)
//    redirect_valid/pc       branch/jump redirect from downstream
//    out_valid/out_ready     queue head handshake to decode
//    out_pc, out_inst        head PC and instruction word
//    out_rs1/rs2/rd          head register fields
//    out_is_jal              head is a JAL
module fetch_buffer #(
   parameter int                ADDR_W   = 16,
   parameter int                INST_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [INST_W-1:0] mem_rsp_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic [4:0]        out_rs1,
   output logic [4:0]        out_rs2,
   output logic [4:0]        out_rd,
   output logic              out_is_jal
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] r_fetch_pc;
   logic [CW-1:0]     r_count;
   logic [CW-1:0]     r_inflight;
   logic [CW-1:0]     r_drop_cnt;
   logic [PW-1:0]     r_q_head;
   logic [PW-1:0]     r_q_tail;
   logic [PW-1:0]     r_a_head;
   logic [PW-1:0]     r_a_tail;

   logic [ADDR_W-1:0] r_q_pc   [DEPTH];
   logic [INST_W-1:0] r_q_inst [DEPTH];
   logic              r_q_jal  [DEPTH];
   logic [ADDR_W-1:0] r_a_pc   [DEPTH];

   logic              w_rsp_keep;
   logic              w_rsp_drop;
   logic              w_rsp_jal;
   logic              w_jal_enq;
   logic              w_credit;
   logic              w_req_fire;
   logic              w_deq;
   logic [ADDR_W-1:0] w_rsp_pc;
   logic signed [20:0] w_jimm;
   logic [ADDR_W-1:0] w_jal_target;
   logic [INST_W-1:0] w_head_inst;

   // A same-cycle redirect wins over an arriving response.
   assign w_rsp_drop = mem_rsp_valid & (r_drop_cnt != '0);
   assign w_rsp_keep = mem_rsp_valid & (r_drop_cnt == '0) & ~redirect_valid;
   assign w_rsp_pc   = r_a_pc[r_a_head];
   assign w_rsp_jal  = (mem_rsp_data[6:0] == 7'b1101111);
   assign w_jal_enq  = w_rsp_keep & w_rsp_jal;

   assign w_jimm       = $signed({mem_rsp_data[31], mem_rsp_data[19:12], mem_rsp_data[20],
                                  mem_rsp_data[30:21], 1'b0});
   assign w_jal_target = w_rsp_pc + ADDR_W'(w_jimm);

   assign w_credit   = ({1'b0, r_count} + {1'b0, r_inflight}) < (CW+1)'(DEPTH);
   // fetch_pc is stale in a JAL-enqueue or redirect cycle, so hold off.
   assign mem_req_valid = ~reset & w_credit & ~redirect_valid & ~w_jal_enq;
   assign mem_req_addr  = r_fetch_pc;
   assign w_req_fire    = mem_req_valid & mem_req_ready;

   assign out_valid   = (r_count != '0);
   assign w_deq       = out_valid & out_ready;
   assign w_head_inst = r_q_inst[r_q_head];
   assign out_pc      = r_q_pc[r_q_head];
   assign out_inst    = w_head_inst;
   assign out_rs1     = w_head_inst[19:15];
   assign out_rs2     = w_head_inst[24:20];
   assign out_rd      = w_head_inst[11:7];
   assign out_is_jal  = r_q_jal[r_q_head];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
         r_count    <= '0;
         r_inflight <= '0;
         r_drop_cnt <= '0;
         r_q_head   <= '0;
         r_q_tail   <= '0;
         r_a_head   <= '0;
         r_a_tail   <= '0;
      end else begin
         if (w_req_fire)
            r_a_tail <= r_a_tail + 1'b1;
         if (mem_rsp_valid)
            r_a_head <= r_a_head + 1'b1;
         r_inflight <= r_inflight + CW'(w_req_fire) - CW'(mem_rsp_valid);

         // No request is issued in redirect/JAL cycles, so everything still
         // outstanding after this cycle's response belongs to the old path.
         if (redirect_valid)
            r_drop_cnt <= r_inflight - CW'(mem_rsp_valid);
         else if (w_jal_enq)
            r_drop_cnt <= r_inflight - 1'b1;
         else if (w_rsp_drop)
            r_drop_cnt <= r_drop_cnt - 1'b1;

         if (redirect_valid) begin
            r_count  <= '0;
            r_q_head <= '0;
            r_q_tail <= '0;
         end else begin
            if (w_rsp_keep)
               r_q_tail <= r_q_tail + 1'b1;
            if (w_deq)
               r_q_head <= r_q_head + 1'b1;
            r_count <= r_count + CW'(w_rsp_keep) - CW'(w_deq);
         end

         if (redirect_valid)
            r_fetch_pc <= redirect_pc;
         else if (w_jal_enq)
            r_fetch_pc <= w_jal_target;
         else if (w_req_fire)
            r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      end
   end

   // Storage needs no reset; validity is carried by the pointers and counts.
   always_ff @(posedge clk) begin
      if (w_req_fire)
         r_a_pc[r_a_tail] <= r_fetch_pc;
      if (w_rsp_keep) begin
         r_q_pc[r_q_tail]   <= w_rsp_pc;
         r_q_inst[r_q_tail] <= mem_rsp_data;
         r_q_jal[r_q_tail]  <= w_rsp_jal;
      end
   end

endmodule
